// File: rtl/id_stage_buffered_pkg.sv
// rtl/id_stage_buffered_pkg.sv - shared RV32I opcode constants and width defaults
package id_stage_buffered_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] NON_OP    = 7'b0000000;
  localparam logic [2:0] NON_FUNC3 = 3'b000;
  localparam logic [6:0] NON_FUNC7 = 7'b0000000;

endpackage

// File: rtl/id_stage_buffered_inst_fifo.sv
// rtl/id_stage_buffered_inst_fifo.sv - synchronous {pc, inst} queue with count, flush and rdy gating
module inst_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; a flush drops any same-cycle push so the slot is left untouched.
  always_ff @(posedge clk) begin
    if (rdy && !flush && push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count carries the extra full bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push_ok) - CW'(pop_ok);
      end
    end
  end

endmodule

// File: rtl/id_stage_buffered.sv
// rtl/id_stage_buffered.sv - queued RV32I decode stage with forwarding, hazard stall and ID/EX slot
module id_stage_buffered
  import id_stage_buffered_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int RA_W       = RA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int FWD_EN     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          flush_i,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XLEN-1:0]               in_pc,
  input  logic [31:0]                   in_inst,
  output logic [RA_W-1:0]               rs1_addr_o,
  output logic [RA_W-1:0]               rs2_addr_o,
  input  logic [XLEN-1:0]               rs1_data_i,
  input  logic [XLEN-1:0]               rs2_data_i,
  input  logic                          ex_wreg_i,
  input  logic                          ex_is_load_i,
  input  logic [RA_W-1:0]               ex_wd_i,
  input  logic [XLEN-1:0]               ex_wdata_i,
  input  logic                          mem_wreg_i,
  input  logic [RA_W-1:0]               mem_wd_i,
  input  logic [XLEN-1:0]               mem_wdata_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [6:0]                    out_opcode,
  output logic [2:0]                    out_func3,
  output logic [6:0]                    out_func7,
  output logic [XLEN-1:0]               out_op1,
  output logic [XLEN-1:0]               out_op2,
  output logic [XLEN-1:0]               out_imm,
  output logic [RA_W-1:0]               out_rd,
  output logic                          out_wreg,
  output logic                          hazard_stall_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam bit FWD_OFF = (FWD_EN == 0);

  logic [XLEN+31:0] head;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      inst;
  logic             fifo_empty;
  logic             fifo_full;
  logic             head_valid;
  logic             issue;

  logic [RA_W-1:0]  rs1;
  logic [RA_W-1:0]  rs2;
  logic [RA_W-1:0]  rd;
  logic [6:0]       opcode;

  logic             known;
  logic             use_rs1;
  logic             use_rs2;
  logic             dec_wreg;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;

  logic             ex_m1, ex_m2, mem_m1, mem_m2;
  logic             hz1, hz2, hazard;
  logic [XLEN-1:0]  op1, op2;

  assign in_ready = rdy & ~rst & ~fifo_full;

  inst_fifo #(
    .W     (XLEN + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush_i),
    .push  (in_valid & in_ready),
    .wdata ({in_pc, in_inst}),
    .pop   (issue),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count_o)
  );

  assign head_valid = ~fifo_empty;
  assign head_pc    = head[XLEN+31:32];
  assign inst       = head[31:0];

  assign opcode     = inst[6:0];
  assign rs1        = inst[19:15];
  assign rs2        = inst[24:20];
  assign rd         = inst[11:7];
  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  // Opcode classification: source usage, writeback and raw 32-bit immediate.
  always_comb begin
    known    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    dec_wreg = 1'b0;
    imm32    = 32'h0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_wreg = 1'b1;
        imm32    = {inst[31:12], 12'h000};
      end
      OPC_JAL: begin
        dec_wreg = 1'b1;
        imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        dec_wreg = 1'b1;
        use_rs1  = 1'b1;
        imm32    = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_OP: begin
        dec_wreg = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      default: known = 1'b0;
    endcase
    if (rd == '0) dec_wreg = 1'b0;
  end

  assign dec_imm = XLEN'($signed(imm32));

  assign ex_m1  = ex_wreg_i  & (ex_wd_i  == rs1);
  assign ex_m2  = ex_wreg_i  & (ex_wd_i  == rs2);
  assign mem_m1 = mem_wreg_i & (mem_wd_i == rs1);
  assign mem_m2 = mem_wreg_i & (mem_wd_i == rs2);

  // Operand priority: x0 or unused, then EX result, then MEM result, then register file.
  assign op1 = (!use_rs1 || rs1 == '0) ? '0 :
               ex_m1  ? ex_wdata_i  :
               mem_m1 ? mem_wdata_i : rs1_data_i;
  assign op2 = (!use_rs2 || rs2 == '0) ? '0 :
               ex_m2  ? ex_wdata_i  :
               mem_m2 ? mem_wdata_i : rs2_data_i;

  // A load in EX cannot be forwarded yet; with forwarding off, any in-flight producer blocks.
  assign hz1 = use_rs1 & (rs1 != '0) & ((ex_m1 & ex_is_load_i) | (FWD_OFF & (ex_m1 | mem_m1)));
  assign hz2 = use_rs2 & (rs2 != '0) & ((ex_m2 & ex_is_load_i) | (FWD_OFF & (ex_m2 | mem_m2)));
  assign hazard         = head_valid & (hz1 | hz2);
  assign hazard_stall_o = hazard;

  assign issue = rdy & ~flush_i & head_valid & ~hazard & (~out_valid | out_ready);

  // ID/EX slot: load on issue, drain on accept, hold under backpressure or rdy=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_opcode <= NON_OP;
      out_func3  <= NON_FUNC3;
      out_func7  <= NON_FUNC7;
      out_op1    <= '0;
      out_op2    <= '0;
      out_imm    <= '0;
      out_rd     <= '0;
      out_wreg   <= 1'b0;
    end else if (rdy) begin
      if (flush_i) begin
        out_valid <= 1'b0;
      end else if (issue) begin
        out_valid  <= 1'b1;
        out_pc     <= known ? head_pc      : '0;
        out_opcode <= known ? opcode       : NON_OP;
        out_func3  <= known ? inst[14:12]  : NON_FUNC3;
        out_func7  <= known ? inst[31:25]  : NON_FUNC7;
        out_op1    <= known ? op1          : '0;
        out_op2    <= known ? op2          : '0;
        out_imm    <= known ? dec_imm      : '0;
        out_rd     <= known ? rd           : '0;
        out_wreg   <= known & dec_wreg;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_buffered.sv
// tb/tb_id_stage_buffered.sv - directed self-checking bench for id_stage_buffered
module tb_id_stage_buffered;

  logic        clk = 1'b0;
  logic        rst, rdy, flush_i, out_ready;
  logic        in_valid, in_valid_b;
  logic [31:0] in_pc, in_inst, in_inst_b;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_wreg, ex_is_load, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata;

  logic        in_ready, out_valid, out_wreg, hazard;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [31:0] out_pc, out_op1, out_op2, out_imm;
  logic [6:0]  out_opcode, out_func7;
  logic [2:0]  out_func3;
  logic [2:0]  fifo_count;

  logic        in_ready_b, out_valid_b, out_wreg_b, hazard_b;
  logic [4:0]  rs1_addr_b, rs2_addr_b, out_rd_b;
  logic [31:0] out_pc_b, out_op1_b, out_op2_b, out_imm_b;
  logic [6:0]  out_opcode_b, out_func7_b;
  logic [2:0]  out_func3_b;
  logic [2:0]  fifo_count_b;

  int tests = 0;
  int fails = 0;
  int acc;

  always #5 clk = ~clk;

  id_stage_buffered #(.FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .ex_wreg_i(ex_wreg), .ex_is_load_i(ex_is_load), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func7(out_func7), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_rd(out_rd), .out_wreg(out_wreg),
    .hazard_stall_o(hazard), .fifo_count_o(fifo_count)
  );

  id_stage_buffered #(.FWD_EN(0)) dut_nofwd (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pc(in_pc), .in_inst(in_inst_b),
    .rs1_addr_o(rs1_addr_b), .rs2_addr_o(rs2_addr_b), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .ex_wreg_i(ex_wreg), .ex_is_load_i(ex_is_load), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_opcode(out_opcode_b),
    .out_func3(out_func3_b), .out_func7(out_func7_b), .out_op1(out_op1_b), .out_op2(out_op2_b),
    .out_imm(out_imm_b), .out_rd(out_rd_b), .out_wreg(out_wreg_b),
    .hazard_stall_o(hazard_b), .fifo_count_o(fifo_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; in_pc = pc; in_inst = ins;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_valid_b = 1'b0; in_pc = '0; in_inst = '0; in_inst_b = '0;
    rs1_data = 32'hDEAD0001; rs2_data = 32'hDEAD0002;
    ex_wreg = 1'b0; ex_is_load = 1'b0; ex_wd = '0; ex_wdata = '0;
    mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
    tick; tick;

    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ADDI x1,x0,5: one edge to queue, one to issue
    push1(32'h0, 32'h00500093);
    chk("addi_lat_valid0", 32'(out_valid), 32'd0);
    chk("addi_count1", 32'(fifo_count), 32'd1);
    tick;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_opcode", 32'(out_opcode), 32'h13);
    chk("addi_op1", out_op1, 32'd0);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_wreg", 32'(out_wreg), 32'd1);
    chk("addi_count0", 32'(fifo_count), 32'd0);

    // ADD x3,x1,x1 with EX and MEM both producing x1
    ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'h10;
    mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h20;
    push1(32'h4, 32'h001081B3);
    chk("add_rs1_addr", 32'(rs1_addr), 32'd1);
    chk("add_no_hazard", 32'(hazard), 32'd0);
    tick;
    chk("fwd_ex_op1", out_op1, 32'h10);
    chk("fwd_ex_op2", out_op2, 32'h10);
    chk("add_rd", 32'(out_rd), 32'd3);
    ex_wreg = 1'b0;
    push1(32'h8, 32'h001081B3);
    tick;
    chk("fwd_mem_op1", out_op1, 32'h20);
    chk("fwd_mem_op2", out_op2, 32'h20);
    chk("fwd_mem_pc", out_pc, 32'h8);

    // Load-use: ADDI x4,x2,1 behind a load to x2
    mem_wreg = 1'b0;
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd2; ex_wdata = 32'h77;
    push1(32'hC, 32'h00110213);
    chk("lu_hazard", 32'(hazard), 32'd1);
    tick;
    chk("lu_no_issue", 32'(out_valid), 32'd0);
    chk("lu_hazard_hold", 32'(hazard), 32'd1);
    chk("lu_count", 32'(fifo_count), 32'd1);
    ex_is_load = 1'b0;
    #1;
    chk("lu_hazard_clear", 32'(hazard), 32'd0);
    tick;
    chk("lu_issue", 32'(out_valid), 32'd1);
    chk("lu_op1", out_op1, 32'h77);
    chk("lu_rd", 32'(out_rd), 32'd4);

    // Forwarding disabled: MEM-only match stalls
    ex_wreg = 1'b0;
    mem_wreg = 1'b1; mem_wd = 5'd2; mem_wdata = 32'h55;
    in_valid_b = 1'b1; in_pc = 32'h10; in_inst_b = 32'h00110213;
    tick;
    in_valid_b = 1'b0;
    chk("nofwd_hazard", 32'(hazard_b), 32'd1);
    tick;
    chk("nofwd_no_issue", 32'(out_valid_b), 32'd0);
    mem_wreg = 1'b0;
    tick;
    chk("nofwd_issue", 32'(out_valid_b), 32'd1);
    chk("nofwd_op1_rf", out_op1_b, 32'hDEAD0001);

    // Backpressure: drain slot, then fill 1 out + 4 queued
    tick;
    chk("bp_slot_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_pc = 32'h100 + 32'(i * 4); in_inst = 32'h00500093;
      if (in_ready) acc++;
      tick;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(fifo_count), 32'd4);
    chk("bp_out_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_pulse_in_ready", 32'(in_ready), 32'd1);
    chk("bp_pulse_count", 32'(fifo_count), 32'd3);
    chk("bp_pulse_pc", out_pc, 32'h104);

    // Flush with 3 queued and a same-cycle push
    flush_i = 1'b1; in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h123450B7;
    tick;
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick;
    chk("flush_drop_count", 32'(fifo_count), 32'd0);
    chk("flush_drop_valid", 32'(out_valid), 32'd0);

    // Immediates and bubble
    out_ready = 1'b1;
    push1(32'h200, 32'hFE000EE3);
    tick;
    chk("beq_opcode", 32'(out_opcode), 32'h63);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_wreg", 32'(out_wreg), 32'd0);
    push1(32'h204, 32'h123450B7);
    tick;
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_wreg", 32'(out_wreg), 32'd1);
    chk("lui_rd", 32'(out_rd), 32'd1);
    push1(32'h208, 32'h0000007F);
    tick;
    chk("bubble_valid", 32'(out_valid), 32'd1);
    chk("bubble_opcode", 32'(out_opcode), 32'd0);
    chk("bubble_wreg", 32'(out_wreg), 32'd0);

    // rdy=0 freezes the slot even with out_ready high
    rdy = 1'b0;
    #1;
    chk("frz_in_ready", 32'(in_ready), 32'd0);
    tick;
    chk("frz_out_valid", 32'(out_valid), 32'd1);
    rdy = 1'b1;
    tick;
    chk("unfrz_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_buffered.md
Name: id_stage_buffered

Overview:
- Next-generation RV32I instruction-decode stage with a parametrised instruction queue between IF and ID.
- Decodes the queue head and forwards operands from EX/MEM.
- Detects load-use and forwarding-disabled hazards, then issues into a registered ID/EX output slot under valid/ready handshake.
- Sits between the IF stage and the EX stage; reads the register file combinationally.

Parameters:
- XLEN, 32, data/address width.
- RA_W, 5, register-address width.
- FIFO_DEPTH, 4, instruction-queue entries; power of two, >=2.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = any EX/MEM match on a used source stalls.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; 0 freezes all state.
- flush_i  in  1  pipeline flush (branch mispredict).
- in_valid  in  1  fetch handshake valid.
- in_ready  out  1  queue can accept.
- in_pc  in  XLEN  fetch PC.
- in_inst  in  32  fetched instruction.
- rs1_addr_o / rs2_addr_o  out  RA_W  register-file read addresses (head inst).
- rs1_data_i / rs2_data_i  in  XLEN  register-file read data (combinational).
- ex_wreg_i, ex_is_load_i  in  1  EX writes rd / EX instruction is a load.
- ex_wd_i  in  RA_W;  ex_wdata_i  in  XLEN.
- mem_wreg_i  in  1;  mem_wd_i  in  RA_W;  mem_wdata_i  in  XLEN.
- out_valid  out  1;  out_ready  in  1  ID/EX handshake.
- out_pc  out  XLEN;  out_opcode  out  7;  out_func3  out  3;  out_func7  out  7.
- out_op1 / out_op2  out  XLEN  resolved rs1/rs2 values.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  RA_W;  out_wreg  out  1.
- hazard_stall_o  out  1  head blocked by hazard this cycle.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

Behaviour:
- Reset: queue empty, out_valid=0, all out_* = 0, hazard_stall_o=0, fifo_count_o=0. in_ready=0 while rst is high.
- rdy=0: no state changes and in_ready=0; out_valid and out fields hold.
- in_ready = rdy & !full. No push-through when full, even if a pop occurs in the same cycle.
- Push when in_valid & in_ready. Push and pop may occur in the same cycle when not full.
- Head decode is combinational:
  - opcode = inst[6:0], func3 = inst[14:12], func7 = inst[31:25], rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
- Immediates:
  - I-type (JALR, LOAD, OP-IMM): inst[31:20] sign-extended.
  - S-type (STORE): {inst[31:25], inst[11:7]} sign-extended.
  - B-type (BRANCH): {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U-type (LUI, AUIPC): {inst[31:12], 12'b0}.
  - J-type (JAL): {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - OP: imm = 0.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 is used by BRANCH, STORE, OP.
- out_wreg = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd != 0.
- Unknown opcode issues as a bubble: opcode = NON_OP (0), wreg = 0, other fields 0.
- Operand resolution per used source, in priority order:
  1. Address x0 -> 0.
  2. EX match (ex_wreg & ex_wd == addr) -> ex_wdata.
  3. MEM match -> mem_wdata.
  4. Otherwise the register-file value.
  - An unused source resolves to 0.
- hazard = head valid & used source != 0 & one of:
  - EX match with ex_is_load_i;
  - FWD_EN = 0 with any EX or MEM match.
- Issue = head valid & !hazard & (!out_valid | out_ready). Issue pops the head and loads the out register at the edge.
- If out_valid & out_ready & !issue, out_valid clears. When out_ready=0, the out register holds.
- hazard_stall_o = hazard & head valid (combinational).
- Latency: an instruction accepted at edge k, with the queue previously empty and no stall, gives out_valid=1 after edge k+1.
- flush_i (when rdy=1):
  - Empties the queue and clears out_valid at the edge.
  - Overrides any same-cycle push and issue; the pushed instruction is dropped.
- Pointer wrap-around: modulo FIFO_DEPTH. Full/empty are distinguished by an extra count bit.

Decomposition:
- Shared package: opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011), NON_OP, NON_FUNC3, NON_FUNC7, and the XLEN/RA_W defaults.
- Sub-module: inst_fifo (parametrised sync FIFO of {pc, inst}, with count, flush, rdy gating).
- Decode, immediate generation, forwarding and hazard logic stay in the top level.

Test Plan:
- Reset, then push ADDI x1,x0,5 (0x00500093, pc 0x0) -> after 2 edges: out_valid=1, opcode 0x13, op1 0, imm 5, rd 1, wreg 1.
- Forwarding: ex_wreg=1, ex_wd=1, ex_wdata=0x10; mem_wreg=1, mem_wd=1, mem_wdata=0x20; push ADD x3,x1,x1 (0x001081B3) -> op1 = op2 = 0x10. With ex_wreg=0 -> op1 = op2 = 0x20.
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=2; head ADDI x4,x2,1 -> hazard_stall_o=1, no issue. Drop ex_is_load next cycle -> issues with op1 = ex_wdata. Repeat with FWD_EN=0 and only a MEM match -> stalls.
- Backpressure: out_ready=0, push 6 instructions -> 5 accepted (4 queued + 1 in out register), then in_ready=0, fifo_count_o=4. Single out_ready pulse -> in_ready=1 next cycle.
- Flush: 3 queued, flush_i=1 with in_valid=1 in the same cycle -> next cycle fifo_count_o=0, out_valid=0, pushed instruction absent.
- Immediates: BEQ x0,x0,-4 (0xFE000EE3) -> imm 0xFFFFFFFC, wreg 0. LUI x1,0x12345 (0x123450B7) -> imm 0x12345000. Opcode 0x7F -> bubble (opcode 0, wreg 0).
